// File: rtl/mips_store_checker.sv
// Snoops the MIPS core's data-memory write port and scores stores into a fixed
// result window against a loadable table of expected words.
module mips_store_checker #(
  parameter logic [31:0] BASE_ADDR = 32'h0000500C,
  parameter int          NSLOT     = 15,
  parameter logic [15:0] TIMEOUT   = 16'd4000
) (
  input  logic        CK,
  input  logic        CLR,
  input  logic        ld_en,
  input  logic [3:0]  ld_idx,
  input  logic [31:0] ld_data,
  input  logic        start,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [4:0]  pass_cnt,
  output logic [4:0]  fail_cnt,
  output logic [3:0]  first_fail_idx,
  output logic [31:0] first_fail_data,
  output logic [7:0]  stray_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [31:0] WIN_BYTES = 32'(4 * NSLOT);
  localparam logic [16:0] FULL17    = (17'd1 << NSLOT) - 17'd1;
  localparam logic [15:0] FULL_MASK = FULL17[15:0];
  localparam logic [4:0]  NSLOT5    = 5'(NSLOT);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_table [16];
  logic [15:0] r_seen;
  logic [15:0] r_cyc;
  logic [4:0]  r_pass_cnt, r_fail_cnt;
  logic [7:0]  r_stray_cnt;
  logic [3:0]  r_ff_idx;
  logic [31:0] r_ff_data;
  logic        r_timeout;

  logic [31:0] w_off;
  logic        w_hit, w_misalign, w_dup, w_run, w_new, w_stray, w_match;
  logic        w_full, w_tmo, w_restart;
  logic [3:0]  w_idx;
  logic [15:0] w_slot_bit, w_seen_nxt;

  // Window decode in 32-bit unsigned arithmetic; below-base addresses wrap and
  // are rejected by the explicit lower-bound compare.
  assign w_off      = mem_addr - BASE_ADDR;
  assign w_hit      = mem_we && (mem_addr >= BASE_ADDR) && (w_off < WIN_BYTES);
  assign w_idx      = w_off[5:2];
  assign w_misalign = |mem_addr[1:0];
  assign w_slot_bit = 16'd1 << w_idx;
  assign w_run      = (r_state == S_RUN);
  assign w_dup      = |(r_seen & w_slot_bit);
  assign w_new      = w_run && w_hit && !w_misalign && !w_dup;
  assign w_stray    = w_run && w_hit && (w_misalign || w_dup);
  assign w_match    = (mem_wdata == r_table[w_idx]);
  assign w_seen_nxt = r_seen | (w_new ? w_slot_bit : 16'd0);
  assign w_full     = ((w_seen_nxt & FULL_MASK) == FULL_MASK);
  assign w_tmo      = (r_cyc == TIMEOUT - 16'd1);
  assign w_restart  = start && (r_state != S_RUN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_full || w_tmo) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!CLR) begin
      r_state     <= S_IDLE;
      r_seen      <= '0;
      r_cyc       <= '0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_stray_cnt <= '0;
      r_ff_idx    <= '0;
      r_ff_data   <= '0;
      r_timeout   <= 1'b0;
      for (int i = 0; i < 16; i++) r_table[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && ld_en && ({1'b0, ld_idx} < NSLOT5))
        r_table[ld_idx] <= ld_data;
      if (w_restart) begin
        r_seen      <= '0;
        r_cyc       <= '0;
        r_pass_cnt  <= '0;
        r_fail_cnt  <= '0;
        r_stray_cnt <= '0;
        r_ff_idx    <= '0;
        r_ff_data   <= '0;
        r_timeout   <= 1'b0;
      end else if (w_run) begin
        r_cyc  <= r_cyc + 16'd1;
        r_seen <= w_seen_nxt;
        if (w_stray && (r_stray_cnt != 8'hFF))
          r_stray_cnt <= r_stray_cnt + 8'd1;
        if (w_new && w_match)
          r_pass_cnt <= r_pass_cnt + 5'd1;
        if (w_new && !w_match) begin
          r_fail_cnt <= r_fail_cnt + 5'd1;
          if (r_fail_cnt == 5'd0) begin
            r_ff_idx  <= w_idx;
            r_ff_data <= mem_wdata;
          end
        end
        // A final store landing on the timeout cycle completes the run cleanly.
        if (w_tmo && !w_full)
          r_timeout <= 1'b1;
      end
    end
  end

  assign busy            = (r_state == S_RUN);
  assign done            = (r_state == S_DONE);
  assign pass            = done && (r_fail_cnt == 5'd0) && !r_timeout;
  assign timeout         = r_timeout;
  assign pass_cnt        = r_pass_cnt;
  assign fail_cnt        = r_fail_cnt;
  assign first_fail_idx  = r_ff_idx;
  assign first_fail_data = r_ff_data;
  assign stray_cnt       = r_stray_cnt;

endmodule

// File: tb/tb_mips_store_checker.sv
// Directed bench for mips_store_checker; the DUT runs with TIMEOUT=64 so the
// timeout boundary is reachable in a short run.
module tb_mips_store_checker;

  logic        CK = 1'b0;
  logic        CLR, ld_en, start, mem_we;
  logic [3:0]  ld_idx;
  logic [31:0] ld_data, mem_addr, mem_wdata;
  logic        busy, done, pass, timeout;
  logic [4:0]  pass_cnt, fail_cnt;
  logic [3:0]  first_fail_idx;
  logic [31:0] first_fail_data;
  logic [7:0]  stray_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_tab [15];

  mips_store_checker #(
    .BASE_ADDR(32'h0000500C), .NSLOT(15), .TIMEOUT(16'd64)
  ) dut (
    .CK(CK), .CLR(CLR), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .start(start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
    .first_fail_data(first_fail_data), .stray_cnt(stray_cnt)
  );

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    mem_we = 1'b1; mem_addr = addr; mem_wdata = data;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic store_slot(input int i, input logic [31:0] data);
    do_store(32'h500C + 32'(4 * i), data);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    CLR = 1'b0;
    tick();
    CLR = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},  {31'd0, busy}, 32'd0);
    check({tag, ".done"},  {31'd0, done}, 32'd0);
    check({tag, ".pass"},  {31'd0, pass}, 32'd0);
    check({tag, ".tmo"},   {31'd0, timeout}, 32'd0);
    check({tag, ".pcnt"},  {27'd0, pass_cnt}, 32'd0);
    check({tag, ".fcnt"},  {27'd0, fail_cnt}, 32'd0);
    check({tag, ".ffi"},   {28'd0, first_fail_idx}, 32'd0);
    check({tag, ".ffd"},   first_fail_data, 32'd0);
    check({tag, ".stray"}, {24'd0, stray_cnt}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic d, input logic p, input logic t,
                              input int pc, input int fc, input int sc);
    check({tag, ".done"},  {31'd0, done}, {31'd0, d});
    check({tag, ".busy"},  {31'd0, busy}, {31'd0, ~d});
    check({tag, ".pass"},  {31'd0, pass}, {31'd0, p});
    check({tag, ".tmo"},   {31'd0, timeout}, {31'd0, t});
    check({tag, ".pcnt"},  {27'd0, pass_cnt}, 32'(pc));
    check({tag, ".fcnt"},  {27'd0, fail_cnt}, 32'(fc));
    check({tag, ".stray"}, {24'd0, stray_cnt}, 32'(sc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_tab = '{32'h335e, 32'h407f, 32'h263d, 32'h345e, 32'h100, 32'h3f7f, 32'h15e,
                32'h33ff, 32'h1, 32'h3, 32'h1, 32'h0, 32'h1, 32'h0, 32'h1};
    CLR = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_data = '0; start = 1'b0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    do_reset();
    check_all_zero("rst");

    // Load slots 0..13, then slot 14 on the same edge as start.
    for (int i = 0; i < 14; i++) begin
      ld_en = 1'b1; ld_idx = 4'(i); ld_data = exp_tab[i];
      tick();
    end
    ld_idx = 4'd14; ld_data = exp_tab[14];
    do_start();
    ld_en = 1'b0;
    check("run1.busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 14; i++) store_slot(i, exp_tab[i]);
    check("run1.done_early", {31'd0, done}, 32'd0);
    store_slot(14, exp_tab[14]);
    check_result("run1", 1'b1, 1'b1, 1'b0, 15, 0, 0);

    // Restart from DONE: counters clear, then two wrong slots.
    do_start();
    check_result("run2.start", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    store_slot(0, exp_tab[0]);
    store_slot(1, 32'h4080);
    check("run2.fcnt_mid", {27'd0, fail_cnt}, 32'd1);
    for (int i = 2; i < 15; i++) store_slot(i, (i == 5) ? 32'hDEAD : exp_tab[i]);
    check_result("run2", 1'b1, 1'b0, 1'b0, 13, 2, 0);
    check("run2.ffi", {28'd0, first_fail_idx}, 32'd1);
    check("run2.ffd", first_fail_data, 32'h4080);

    // Strays: duplicate, misaligned, outside-window stores on both edges.
    do_start();
    store_slot(0, exp_tab[0]);
    do_store(32'h500C, 32'h9999);
    do_store(32'h500E, 32'h335e);
    do_store(32'h6000, 32'h1234);
    do_store(32'h5008, 32'h1234);
    do_store(32'h5048, 32'h1234);
    check("run3.stray_mid", {24'd0, stray_cnt}, 32'd2);
    for (int i = 1; i < 15; i++) store_slot(i, exp_tab[i]);
    check_result("run3", 1'b1, 1'b1, 1'b0, 15, 0, 2);

    // Timeout with one slot missing: done exactly 64 edges after start.
    do_start();
    for (int i = 0; i < 14; i++) store_slot(i, exp_tab[i]);
    for (int k = 0; k < 49; k++) tick();
    check("tmo.done_63", {31'd0, done}, 32'd0);
    tick();
    check_result("tmo", 1'b1, 1'b0, 1'b1, 14, 0, 0);

    // Last slot on the timeout edge: full path wins.
    do_start();
    for (int i = 0; i < 14; i++) store_slot(i, exp_tab[i]);
    for (int k = 0; k < 49; k++) tick();
    check("tie.done_63", {31'd0, done}, 32'd0);
    store_slot(14, exp_tab[14]);
    check_result("tie", 1'b1, 1'b1, 1'b0, 15, 0, 0);

    // Reset mid-run, then stores in IDLE are ignored.
    do_start();
    for (int i = 0; i < 5; i++) store_slot(i, exp_tab[i]);
    check("abort.pcnt_pre", {27'd0, pass_cnt}, 32'd5);
    do_reset();
    check_all_zero("abort");
    for (int i = 0; i < 5; i++) store_slot(i, exp_tab[i]);
    check_all_zero("idle_st");

    // Table was cleared by reset; loads during RUN are ignored.
    do_start();
    store_slot(0, 32'h0);
    check("tbl0.pcnt", {27'd0, pass_cnt}, 32'd1);
    ld_en = 1'b1; ld_idx = 4'd1; ld_data = 32'h4080;
    tick();
    ld_en = 1'b0;
    store_slot(1, 32'h4080);
    check("ldrun.fcnt", {27'd0, fail_cnt}, 32'd1);
    check("ldrun.ffi", {28'd0, first_fail_idx}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_store_checker.md
# mips_store_checker

Self-checking result monitor placed directly downstream of the `MIPSmulticycle` core's data-memory write port. It snoops every store the core issues and compares stores into a fixed result window against a loadable table of expected words. It reports pass/fail counts, the first mismatch, stray stores and completion, which replaces manual end-of-run memory dumps.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000500C: byte address of result slot 0.
- `NSLOT`, 15: number of 32-bit result slots, 1..16.
- `TIMEOUT`, 16'd4000: maximum `RUN` cycles before a forced finish.

Ports:
- `CK` in 1: clock; all state changes on the rising edge.
- `CLR` in 1: synchronous, active-low reset.
- `ld_en` in 1: write expected-table entry; honoured only in `IDLE`.
- `ld_idx` in 4: table index; values >= `NSLOT` are ignored.
- `ld_data` in 32: expected word.
- `start` in 1: begin checking; honoured in `IDLE` and `DONE`.
- `mem_we` in 1: core memory write strobe.
- `mem_addr` in 32: core memory byte address.
- `mem_wdata` in 32: core store data.
- `busy` out 1: state is `RUN`.
- `done` out 1: state is `DONE`.
- `pass` out 1: `done` & `fail_cnt`==0 & `timeout`==0.
- `timeout` out 1: the run ended by `TIMEOUT`.
- `pass_cnt` out 5: matching first stores.
- `fail_cnt` out 5: mismatching first stores.
- `first_fail_idx` out 4: slot of the earliest mismatch.
- `first_fail_data` out 32: data of the earliest mismatch.
- `stray_cnt` out 8: misaligned or duplicate window stores; saturates at 255.

## Operation
- States: `IDLE` -> `RUN` -> `DONE`.
  - `IDLE`: table loads are accepted; snoop input is ignored.
  - `start` in `IDLE` or `DONE` -> `RUN`. On the same edge, clear the seen bitmap, all counters, `timeout`, the first-fail registers and the cycle counter. The table is kept.
  - `start` in `RUN` is ignored.
- Window hit: `mem_we`=1 and `BASE_ADDR` <= `mem_addr` < `BASE_ADDR`+4·`NSLOT`.
  - Slot index = (`mem_addr`−`BASE_ADDR`)>>2, computed in 32-bit unsigned arithmetic.
  - Stores outside the window are ignored.
- Rules in `RUN` for a window hit:
  - Misaligned (`mem_addr`[1:0]!=0): `stray_cnt`+1. No compare.
  - Slot already seen: `stray_cnt`+1. No re-compare; the first result stands.
  - Slot unseen: mark seen and compare `mem_wdata` to the table entry.
    - Equal: `pass_cnt`+1.
    - Not equal: `fail_cnt`+1. If this is the first failure, latch `first_fail_idx` and `first_fail_data`.
- Completion:
  - `RUN` -> `DONE` when the bitmap becomes full (all `NSLOT` bits set).
  - Also `RUN` -> `DONE` when the cycle counter reaches `TIMEOUT`−1 with slots still missing; set `timeout`=1.
  - If the last slot fills on the timeout cycle, the bitmap-full path wins and `timeout`=0.
- `DONE`: counters and flags hold; snoop input is ignored until the next `start`.
- `ld_en` and `start` asserted together in `IDLE`: the load takes effect and is used by the run. `ld_en` outside `IDLE` is ignored.

## Timing
- Reset: `CLR`=0 at a rising edge forces state `IDLE` and clears the table to 0. Every output goes to 0: `busy`, `done`, `pass`, `timeout`, both counters, `first_fail_*` and `stray_cnt`. Reset mid-run aborts the run with no residue.
- Snoop sampling: a store is sampled at edge N. Its counter and bitmap effect is visible after edge N (one-cycle latency).
- `done`/`busy` change on that same edge. `done` is therefore high in the cycle after the final store is sampled.
- `pass` is combinational from registered state. It never glitches high while `busy`=1.
- Back-to-back stores are handled on consecutive cycles with no stall or backpressure. The block never drives the core.
- Cycle counter: 16 bits, increments every `RUN` cycle, cleared by `start`.

## Test plan
- All 15 correct stores (table 335e, 407f, 263d, 345e, 100, 3f7f, 15e, 33ff, 1, 3, 1, 0, 1, 0, 1 at 0x500C..0x5044) -> `done`=1 one cycle after the last store; `pass`=1, `pass_cnt`=15, `fail_cnt`=0, `stray_cnt`=0.
- Slot 1 (0x5010) stored as 0x4080, and slot 5 stored wrong afterwards -> `fail_cnt`=2, `pass_cnt`=13, `first_fail_idx`=1, `first_fail_data`=0x4080, `pass`=0.
- Extra store to 0x500C and a store to 0x500E, plus a store to 0x6000 -> `stray_cnt`=2; the 0x6000 store has no effect; other results are unchanged.
- `TIMEOUT`=64 with only 14 slots written -> `done`=1 exactly 64 cycles after `start`; `timeout`=1, `pass`=0, `pass_cnt`=14.
- `CLR` low for one edge after 5 stores in `RUN` -> all outputs 0 and state `IDLE`. Stores in `IDLE` then leave the counters at 0.
- Second `start` from `DONE` with the table unchanged -> counters clear on the start edge and a repeated correct run gives `pass`=1 again.
